lc3_mem_responder: RTL and testbench

Memory-side responder for the LC-3 datapath's MAR/MDR memory interface. It accepts read and write requests driven by the control unit (mem_en, mem_rw, MAR address, MDR write data). Each request is serviced after a fixed, parameterised latency and acknowledged with a ready/hold handshake. The block also decodes the LC-3 display device registers DSR and DDR, and forwards characters written to DDR out a valid/ready port.

---
 rtl/lc3_mem_responder.sv | 134 +++++++++++++
 tb/tb_lc3_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder: fixed-latency RAM access with a four-phase
// ready handshake, plus the DSR/DDR display registers and a valid/ready character port.
module lc3_mem_responder #(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 1024,
    parameter int                LATENCY  = 2,
    parameter logic [DATA_W-1:0] DSR_ADDR = 16'hFE04,
    parameter logic [DATA_W-1:0] DDR_ADDR = 16'hFE06
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              mem_rw,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic [7:0]        disp_data,
    output logic              disp_valid,
    input  logic              disp_ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_rw;

    logic [DATA_W-1:0] ram [DEPTH];

    logic              commit;
    logic              hit_dsr;
    logic              hit_ddr;
    logic              ram_we;
    logic              ddr_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] rd_value;

    assign commit  = (state == ST_BUSY) && (cnt == '0);
    assign hit_dsr = (req_addr == DSR_ADDR);
    assign hit_ddr = !hit_dsr && (req_addr == DDR_ADDR);
    assign ram_idx = req_addr[IDX_W-1:0];
    assign ram_we  = commit && req_rw && !hit_dsr && !hit_ddr;
    assign ddr_we  = commit && req_rw && hit_ddr;

    // Read mux sampled on the completion edge, so it sees memory as of that edge.
    always_comb begin
        // NOTE: every path through an always_comb must assign each output;
        // the default here keeps rd_value from becoming a latch.
        rd_value = ram[ram_idx];
        if (hit_dsr) begin
            rd_value = {~disp_valid, {(DATA_W-1){1'b0}}};
        end else if (hit_ddr) begin
            rd_value = {{(DATA_W-8){1'b0}}, disp_data};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_rw    <= 1'b0;
            rdata     <= '0;
            mem_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_en) begin
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        req_rw    <= mem_rw;
                        cnt       <= CNT_LOAD;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        if (!req_rw) begin
                            rdata <= rd_value;
                        end
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!mem_en) begin
                        mem_ready <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; clearing it would forbid block-RAM
    // mapping, and software never relies on power-up contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= req_wdata;
        end
    end

    // A pending character is only replaced when it is leaving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else if (ddr_we && (!disp_valid || disp_ready)) begin
            disp_valid <= 1'b1;
            disp_data  <= req_wdata[7:0];
        end else if (disp_valid && disp_ready) begin
            disp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed scenarios plus randomized
// accesses compared against a word-array and display-register model.
module tb_lc3_mem_responder;

    localparam int          DATA_W  = 16;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;
    localparam logic [15:0] DSR     = 16'hFE04;
    localparam logic [15:0] DDR     = 16'hFE06;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_rw = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        mem_ready;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [DEPTH];
    bit          m_dv;
    logic [7:0]  m_dd;
    logic [15:0] m_rdata;
    logic [9:0]  pool [8];

    always #5 clk = ~clk;

    lc3_mem_responder #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY),
        .DSR_ADDR(DSR), .DDR_ADDR(DDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_rw(mem_rw),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: display model follows the valid/ready/DDR-write rules.
    task automatic step(input bit ddr_wr, input logic [7:0] ch);
        bit dr;
        dr = disp_ready;
        @(posedge clk);
        if (ddr_wr && (!m_dv || dr)) begin
            m_dd = ch;
            m_dv = 1'b1;
        end else if (m_dv && dr) begin
            m_dv = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic access(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                          input int hold, input bit cancel, input int dr_commit);
        logic [15:0] exp;
        mem_en = 1'b1;
        mem_rw = rw;
        addr   = a;
        wdata  = wd;
        step(1'b0, 8'h00);
        check("accept_not_ready", 16'(mem_ready), 16'd0);
        mem_rw = 1'($urandom);
        addr   = 16'($urandom);
        wdata  = 16'($urandom);
        if (cancel) mem_en = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            if (k == LATENCY) begin
                if (a == DSR)      exp = {~m_dv, 15'b0};
                else if (a == DDR) exp = {8'h00, m_dd};
                else               exp = m_mem[a % DEPTH];
                if (dr_commit >= 0) disp_ready = dr_commit[0];
                step(rw && (a == DDR), wd[7:0]);
                if (dr_commit >= 0) disp_ready = 1'b0;
                if (rw && a != DSR && a != DDR) m_mem[a % DEPTH] = wd;
                if (!rw) m_rdata = exp;
                check("ready_at_latency", 16'(mem_ready), 16'd1);
                check(rw ? "rdata_kept_on_write" : "rdata_read", rdata, m_rdata);
            end else begin
                step(1'b0, 8'h00);
                check("busy_not_ready", 16'(mem_ready), 16'd0);
            end
        end
        if (cancel) begin
            step(1'b0, 8'h00);
            check("cancel_single_pulse", 16'(mem_ready), 16'd0);
        end else begin
            for (int h = 0; h < hold; h++) begin
                // Drive a conflicting write; it must not be accepted while in DONE.
                mem_rw = 1'b1;
                addr   = a;
                wdata  = ~wd;
                step(1'b0, 8'h00);
                check("hold_ready", 16'(mem_ready), 16'd1);
                check("hold_rdata", rdata, m_rdata);
            end
            mem_en = 1'b0;
            step(1'b0, 8'h00);
            check("release_clears_ready", 16'(mem_ready), 16'd0);
        end
        check("disp_valid", 16'(disp_valid), 16'(m_dv));
        check("disp_data", 16'(disp_data), 16'(m_dd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        int op;
        m_dv = 1'b0;
        m_dd = 8'h00;
        m_rdata = 16'h0000;

        #3;
        check("reset_rdata", rdata, 16'h0000);
        check("reset_ready", 16'(mem_ready), 16'd0);
        check("reset_disp_valid", 16'(disp_valid), 16'd0);
        check("reset_disp_data", 16'(disp_data), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back
        access(1'b1, 16'h3000, 16'hBEEF, 0, 1'b0, -1);
        access(1'b0, 16'h3000, 16'h0000, 0, 1'b0, -1);
        check("wr_rd_beef", rdata, 16'hBEEF);

        // Aliasing modulo DEPTH
        access(1'b1, 16'h0005, 16'h1234, 0, 1'b0, -1);
        access(1'b0, 16'h0405, 16'h0000, 0, 1'b0, -1);
        check("alias_0405", rdata, 16'h1234);

        // Long hold, then early release in BUSY
        access(1'b1, 16'h0100, 16'h1111, 5, 1'b0, -1);
        access(1'b0, 16'h0100, 16'h0000, 5, 1'b0, -1);
        check("hold_no_second_access", rdata, 16'h1111);
        access(1'b0, 16'h3000, 16'h0000, 0, 1'b1, -1);
        access(1'b1, 16'h0200, 16'h2222, 0, 1'b1, -1);
        access(1'b0, 16'h0200, 16'h0000, 0, 1'b0, -1);
        check("cancelled_write_done", rdata, 16'h2222);

        // Display path
        disp_ready = 1'b0;
        access(1'b0, DSR, 16'h0000, 0, 1'b0, -1);
        check("dsr_idle", rdata, 16'h8000);
        access(1'b1, DDR, 16'h0041, 0, 1'b0, -1);
        check("ddr_valid", 16'(disp_valid), 16'd1);
        check("ddr_char_41", 16'(disp_data), 16'h0041);
        access(1'b0, DSR, 16'h0000, 0, 1'b0, -1);
        check("dsr_busy", rdata, 16'h0000);
        access(1'b1, DDR, 16'h0042, 0, 1'b0, -1);
        check("ddr_drop_keeps_41", 16'(disp_data), 16'h0041);
        access(1'b0, DDR, 16'h0000, 0, 1'b0, -1);
        check("ddr_read_41", rdata, 16'h0041);
        disp_ready = 1'b1;
        step(1'b0, 8'h00);
        disp_ready = 1'b0;
        check("ddr_consumed", 16'(disp_valid), 16'd0);

        // Transfer and DDR write on the same edge
        access(1'b1, DDR, 16'h0041, 0, 1'b0, -1);
        access(1'b1, DDR, 16'h0043, 0, 1'b0, 1);
        check("simul_valid", 16'(disp_valid), 16'd1);
        check("simul_char_43", 16'(disp_data), 16'h0043);
        disp_ready = 1'b1;
        step(1'b0, 8'h00);
        disp_ready = 1'b0;

        // Randomized traffic over a pre-written address pool
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom_range(0, 511));
            access(1'b1, {6'($urandom), pool[i]}, 16'($urandom), 0, 1'b0, -1);
        end
        for (int i = 0; i < 150; i++) begin
            disp_ready = 1'($urandom);
            op = $urandom_range(0, 9);
            if (op < 6)       a = {6'($urandom), pool[$urandom_range(0, 7)]};
            else if (op == 6) a = DSR;
            else              a = DDR;
            access((op == 6) ? 1'b0 : 1'($urandom), a, 16'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                   $urandom_range(0, 2) - 1);
        end
        disp_ready = 1'b0;

        // Reset during BUSY aborts the write
        access(1'b1, 16'h0010, 16'h5555, 0, 1'b0, -1);
        mem_en = 1'b1;
        mem_rw = 1'b1;
        addr   = 16'h0010;
        wdata  = 16'hAAAA;
        step(1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        m_dv = 1'b0;
        m_dd = 8'h00;
        m_rdata = 16'h0000;
        check("rst_busy_ready", 16'(mem_ready), 16'd0);
        check("rst_busy_rdata", rdata, 16'h0000);
        check("rst_busy_disp_valid", 16'(disp_valid), 16'd0);
        mem_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 16'h0010, 16'h0000, 0, 1'b0, -1);
        check("rst_abort_no_write", rdata, 16'h5555);

        // Reset while DONE drops mem_ready at once
        mem_en = 1'b1;
        mem_rw = 1'b0;
        addr   = 16'h3000;
        for (int k = 0; k <= LATENCY; k++) step(1'b0, 8'h00);
        check("done_ready_before_rst", 16'(mem_ready), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_ready", 16'(mem_ready), 16'd0);
        check("rst_done_rdata", rdata, 16'h0000);
        mem_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
